montador_instrucao: RTL and testbench

Sequential RV32I instruction assembler. It is the encoding counterpart of the immediate generator: it takes decoded fields (format, opcode, registers, functs, full-width immediate) over a valid/ready handshake and packs them into a 32-bit instruction word. It range-checks the immediate and writes the word into instruction memory at an auto-incrementing word address, with a memory acknowledge. It is used to load test programs into the CPU's instruction memory.

---
 rtl/montador_instrucao.sv | 121 ++++++++++++
 tb/tb_montador_instrucao.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/montador_instrucao.sv
// RV32I instruction assembler: packs decoded fields into a 32-bit word, range-checks
// the immediate and writes it to instruction memory at an auto-incrementing address.
module montador_instrucao #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              limpa,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        formato,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              erro,
   output logic [ADDR_W:0]   n_escritas
);

   // Handshake: a bundle transfers on a rising edge where in_valid && in_ready;
   // a write completes on a rising edge where mem_we && mem_ack.
   typedef enum logic [1:0] {OCIOSO, ESCREVE, ERRO} estado_t;

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   CNT_MAX = '1;
   localparam logic signed [31:0] LIM12_MIN = -32'sd2048;
   localparam logic signed [31:0] LIM12_MAX = 32'sd2047;
   localparam logic signed [31:0] LIMB_MIN  = -32'sd4096;
   localparam logic signed [31:0] LIMB_MAX  = 32'sd4094;
   localparam logic signed [31:0] LIMJ_MIN  = -32'sd1048576;
   localparam logic signed [31:0] LIMJ_MAX  = 32'sd1048574;

   estado_t            estado, prox_estado;
   logic [31:0]        palavra;
   logic               valido;
   logic signed [31:0] imm_s;

   assign imm_s = imm;

   always_comb begin
      palavra = '0;
      valido  = 1'b0;
      case (formato)
         3'd0: begin
            palavra = {funct7, rs2, rs1, funct3, rd, opcode};
            valido  = 1'b1;
         end
         3'd1: begin
            palavra = {imm[11:0], rs1, funct3, rd, opcode};
            valido  = (imm_s >= LIM12_MIN) && (imm_s <= LIM12_MAX);
         end
         3'd2: begin
            palavra = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            valido  = (imm_s >= LIM12_MIN) && (imm_s <= LIM12_MAX);
         end
         3'd3: begin
            palavra = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            valido  = (imm_s >= LIMB_MIN) && (imm_s <= LIMB_MAX) && !imm[0];
         end
         3'd4: begin
            palavra = {imm[31:12], rd, opcode};
            valido  = (imm[11:0] == 12'd0);
         end
         3'd5: begin
            palavra = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            valido  = (imm_s >= LIMJ_MIN) && (imm_s <= LIMJ_MAX) && !imm[0];
         end
         default: begin
            palavra = '0;
            valido  = 1'b0;
         end
      endcase
   end

   always_comb begin
      prox_estado = estado;
      case (estado)
         OCIOSO:  if (in_valid) prox_estado = valido ? ESCREVE : ERRO;
         ESCREVE: if (mem_ack) prox_estado = OCIOSO;
         ERRO:    prox_estado = OCIOSO;
         default: prox_estado = OCIOSO;
      endcase
      // limpa overrides any accept or pending write
      if (limpa) prox_estado = OCIOSO;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado <= OCIOSO;
      else        estado <= prox_estado;
   end

   assign in_ready = (estado == OCIOSO);
   assign mem_we   = (estado == ESCREVE);
   assign erro     = (estado == ERRO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr   <= BASE;
         mem_wdata  <= '0;
         n_escritas <= '0;
      end else if (limpa) begin
         mem_addr   <= BASE;
         n_escritas <= '0;
      end else begin
         if (estado == OCIOSO && in_valid && valido) mem_wdata <= palavra;
         if (estado == ESCREVE && mem_ack) begin
            mem_addr <= mem_addr + 1'b1;
            if (n_escritas != CNT_MAX) n_escritas <= n_escritas + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_montador_instrucao.sv
// Bench for montador_instrucao: directed bundles, a transaction-level model compared
// every cycle on two instances (ADDR_W=8 and ADDR_W=2), plus literal encodings.
module tb_montador_instrucao;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        limpa = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  formato = '0;
   logic [6:0]  opcode = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic [31:0] imm = '0;
   logic        mem_ack = 1'b0;

   logic        a_ready, a_we, a_erro;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [8:0]  a_n;
   logic        b_ready, b_we, b_erro;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_n;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   montador_instrucao #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .limpa(limpa), .in_valid(in_valid), .in_ready(a_ready),
      .formato(formato), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm), .mem_we(a_we), .mem_addr(a_addr),
      .mem_wdata(a_wdata), .mem_ack(mem_ack), .erro(a_erro), .n_escritas(a_n)
   );

   montador_instrucao #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .limpa(limpa), .in_valid(in_valid), .in_ready(b_ready),
      .formato(formato), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm), .mem_we(b_we), .mem_addr(b_addr),
      .mem_wdata(b_wdata), .mem_ack(mem_ack), .erro(b_erro), .n_escritas(b_n)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] enc_model(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
      logic [31:0] w;
      w = '0;
      w[6:0] = op;
      if (f != 3'd2 && f != 3'd3) w[11:7] = d;
      if (f <= 3'd3) begin
         w[14:12] = f3;
         w[19:15] = s1;
      end
      if (f == 3'd0 || f == 3'd2 || f == 3'd3) w[24:20] = s2;
      case (f)
         3'd0: w[31:25] = f7;
         3'd1: w[31:20] = im[11:0];
         3'd2: begin w[11:7] = im[4:0]; w[31:25] = im[11:5]; end
         3'd3: begin
            w[7] = im[11]; w[11:8] = im[4:1]; w[30:25] = im[10:5]; w[31] = im[12];
         end
         3'd4: w[31:12] = im[31:12];
         3'd5: begin
            w[19:12] = im[19:12]; w[20] = im[11]; w[30:21] = im[10:1]; w[31] = im[20];
         end
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic bit valid_model(input logic [2:0] f, input logic [31:0] im);
      int v;
      v = signed'(im);
      case (f)
         3'd0: return 1'b1;
         3'd1, 3'd2: return (v >= -2048 && v <= 2047);
         3'd3: return (v >= -4096 && v <= 4094 && im[0] == 1'b0);
         3'd4: return (im[11:0] == 12'd0);
         3'd5: return (v >= -1048576 && v <= 1048574 && im[0] == 1'b0);
         default: return 1'b0;
      endcase
   endfunction

   bit          m_busy = 1'b0;
   bit          m_err = 1'b0;
   int          m_writes = 0;
   logic [31:0] m_word = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_err <= 1'b0; m_writes <= 0; m_word <= '0;
      end else if (limpa) begin
         m_busy <= 1'b0; m_err <= 1'b0; m_writes <= 0;
      end else if (m_busy) begin
         if (mem_ack) begin
            m_busy   <= 1'b0;
            m_writes <= m_writes + 1;
         end
      end else if (m_err) begin
         m_err <= 1'b0;
      end else if (in_valid) begin
         if (valid_model(formato, imm)) begin
            m_busy <= 1'b1;
            m_word <= enc_model(formato, opcode, rd, rs1, rs2, funct3, funct7, imm);
         end else begin
            m_err <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (cmp_en) begin
         check("a in_ready", a_ready, !m_busy && !m_err);
         check("a mem_we", a_we, m_busy);
         check("a erro", a_erro, m_err);
         check("a mem_addr", a_addr, m_writes % 256);
         check("a mem_wdata", a_wdata, m_word);
         check("a n_escritas", a_n, (m_writes > 511) ? 511 : m_writes);
         check("b mem_we", b_we, m_busy);
         check("b erro", b_erro, m_err);
         check("b mem_addr", b_addr, m_writes % 4);
         check("b mem_wdata", b_wdata, m_word);
         check("b n_escritas", b_n, (m_writes > 7) ? 7 : m_writes);
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
      formato = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
      funct3 = f3; funct7 = f7; imm = im;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wr(input string name, input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im, input logic [31:0] exp_word,
      input logic [7:0] exp_addr);
      send(f, op, d, s1, s2, f3, f7, im);
      check({name, " we"}, a_we, 1'b1);
      check({name, " word"}, a_wdata, exp_word);
      check({name, " addr"}, a_addr, exp_addr);
      step();
      check({name, " we after ack"}, a_we, 1'b0);
      check({name, " addr after ack"}, a_addr, exp_addr + 8'd1);
   endtask

   task automatic err_case(input string name, input logic [2:0] f, input logic [31:0] im,
      input logic [7:0] exp_addr, input logic [8:0] exp_n);
      send(f, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, im);
      check({name, " erro"}, a_erro, 1'b1);
      check({name, " in_ready"}, a_ready, 1'b0);
      check({name, " we"}, a_we, 1'b0);
      step();
      check({name, " erro clears"}, a_erro, 1'b0);
      check({name, " addr"}, a_addr, exp_addr);
      check({name, " n"}, a_n, exp_n);
   endtask

   initial begin
      @(posedge clk);
      @(negedge clk);
      check("reset in_ready", a_ready, 1'b1);
      check("reset mem_we", a_we, 1'b0);
      check("reset addr", a_addr, 8'd0);
      check("reset wdata", a_wdata, 32'd0);
      check("reset erro", a_erro, 1'b0);
      check("reset n", a_n, 9'd0);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      mem_ack = 1'b1;
      step();

      wr("addi", 3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF08113, 8'd0);
      check("addi n", a_n, 9'd1);

      limpa = 1'b1;
      step();
      limpa = 1'b0;
      wr("sw", 3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 32'h00512423, 8'd0);
      wr("beq", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 32'hFE208EE3, 8'd1);
      wr("lui", 3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123451B7, 8'd2);
      wr("jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 8'd3);
      send(3'd0, 7'h33, 5'd2, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
      check("add word", a_wdata, 32'h00310133);
      check("wrap 5th write b addr", b_addr, 2'd0);
      step();
      check("add n", a_n, 9'd5);

      err_case("I imm 2048", 3'd1, 32'd2048, 8'd5, 9'd5);
      err_case("B imm 3", 3'd3, 32'd3, 8'd5, 9'd5);
      err_case("U imm 1", 3'd4, 32'd1, 8'd5, 9'd5);
      err_case("formato 6", 3'd6, 32'd0, 8'd5, 9'd5);
      wr("I imm 2047", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF00093, 8'd5);

      mem_ack = 1'b0;
      send(3'd0, 7'h33, 5'd2, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp we held", a_we, 1'b1);
         check("bp word held", a_wdata, 32'h00310133);
         check("bp addr held", a_addr, 8'd6);
         check("bp in_ready", a_ready, 1'b0);
      end
      mem_ack = 1'b1;
      step();
      check("bp n", a_n, 9'd7);
      wr("lui 8th", 3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123451B7, 8'd7);
      check("a n 8", a_n, 9'd8);
      check("b n saturates", b_n, 3'd7);

      limpa = 1'b1;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      limpa = 1'b0;
      check("limpa+valid we", a_we, 1'b0);
      check("limpa+valid ready", a_ready, 1'b1);
      check("limpa+valid addr", a_addr, 8'd0);
      check("limpa+valid n", a_n, 9'd0);

      wr("pre-reset", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 8'd0);
      mem_ack = 1'b0;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
      check("pre-reset we", a_we, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset we", a_we, 1'b0);
      check("async reset addr", a_addr, 8'd0);
      check("async reset n", a_n, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      step();

      wr("pre-limpa", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h00700093, 8'd0);
      mem_ack = 1'b0;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
      limpa = 1'b1;
      mem_ack = 1'b1;
      step();
      limpa = 1'b0;
      check("limpa abort ready", a_ready, 1'b1);
      check("limpa abort we", a_we, 1'b0);
      check("limpa abort addr", a_addr, 8'd0);
      check("limpa abort n", a_n, 9'd0);
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
